// File: rtl/uart_irq_service.sv
// Interrupt servicing engine for the UART controller: turns irq/interrupt_type into a single
// register-bus access and moves bytes to and from the host valid/ready streams.
module uart_irq_service #(
    parameter logic [2:0]  RBR_ADDR = 3'd0,
    parameter logic [2:0]  LSR_ADDR = 3'd5,
    parameter int unsigned HOLDOFF  = 2,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       irq,
    input  logic [2:0] interrupt_type,
    output logic       bus_req,
    output logic       bus_we,
    output logic [2:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_ack,
    input  logic [7:0] bus_rdata,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] err_status,
    output logic       err_valid,
    output logic       bus_timeout,
    output logic       busy
);

    localparam int unsigned CNT_MAX = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, OUT, HOLD} state_t;
    typedef enum logic [1:0] {OP_ERR, OP_RX, OP_TX} op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [2:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       err_status_q, err_status_d;
    logic             err_valid_q, err_valid_d;
    logic             timeout_q, timeout_d;
    logic             tx_take;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_ERR;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 3'd0;
            wdata_q      <= 8'd0;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            err_status_q <= 8'd0;
            err_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            err_status_q <= err_status_d;
            err_valid_q  <= err_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        err_status_d = err_status_q;
        err_valid_d  = 1'b0;
        timeout_d    = 1'b0;
        tx_take      = 1'b0;

        case (state_q)
            IDLE: begin
                if (irq) begin
                    case (interrupt_type)
                        3'b001: begin
                            state_d = ISSUE;
                            op_d    = OP_ERR;
                            req_d   = 1'b1;
                            we_d    = 1'b0;
                            addr_d  = LSR_ADDR;
                            cnt_d   = '0;
                        end
                        3'b010: begin
                            state_d = ISSUE;
                            op_d    = OP_RX;
                            req_d   = 1'b1;
                            we_d    = 1'b0;
                            addr_d  = RBR_ADDR;
                            cnt_d   = '0;
                        end
                        3'b011: begin
                            // Without a byte to send, keep re-evaluating the interrupt
                            if (tx_valid) begin
                                tx_take = 1'b1;
                                state_d = ISSUE;
                                op_d    = OP_TX;
                                req_d   = 1'b1;
                                we_d    = 1'b1;
                                addr_d  = RBR_ADDR;
                                wdata_d = tx_data;
                                cnt_d   = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ISSUE: begin
                // Ack takes precedence over an expiring timeout in the same cycle
                if (bus_ack) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                    case (op_q)
                        OP_RX: begin
                            rx_data_d  = bus_rdata;
                            rx_valid_d = 1'b1;
                            state_d    = OUT;
                        end
                        OP_ERR: begin
                            err_status_d = bus_rdata;
                            err_valid_d  = 1'b1;
                            state_d      = HOLD;
                        end
                        default: state_d = HOLD;
                    endcase
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUT: begin
                if (rx_ready) begin
                    rx_valid_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_req     = req_q;
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = tx_take;
    assign err_status  = err_status_q;
    assign err_valid   = err_valid_q;
    assign bus_timeout = timeout_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_irq_service.sv
// Directed bench for uart_irq_service: reset, rx, backpressure, error, tx, timeout scenarios.
module tb_uart_irq_service;

    logic       clk = 1'b0;
    logic       rst;
    logic       irq;
    logic [2:0] interrupt_type;
    logic       bus_req;
    logic       bus_we;
    logic [2:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ack;
    logic [7:0] bus_rdata;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] err_status;
    logic       err_valid;
    logic       bus_timeout;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_irq_service dut (
        .clk(clk), .rst(rst), .irq(irq), .interrupt_type(interrupt_type),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .err_status(err_status), .err_valid(err_valid),
        .bus_timeout(bus_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; registered outputs are then settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq = 1'b0; interrupt_type = 3'b000; bus_ack = 1'b0; bus_rdata = 8'h00;
        rx_ready = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
        step(); step();
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, rx_data, rx_valid, tx_ready,
             err_status, err_valid, bus_timeout, busy} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b rxv=%b busy=%b err=%h rxd=%h, need all 0",
                     bus_req, rx_valid, busy, err_status, rx_data);
        end
        rst = 1'b0;
        step();
        // Start an rx service and reset while the request is outstanding
        irq = 1'b1; interrupt_type = 3'b010;
        step();
        checks++;
        if (bus_req !== 1'b1) begin
            errors++; $display("FAIL reset_pre_issue: bus_req=%b need 1", bus_req);
        end
        irq = 1'b0; rst = 1'b1;
        step();
        checks++;
        if ({bus_req, rx_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_issue: req/rxv/busy=%b need 000", {bus_req, rx_valid, busy});
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_rx();
        irq = 1'b1; interrupt_type = 3'b010; rx_ready = 1'b1;
        step();
        checks++;
        if ({bus_req, bus_we, bus_addr, busy} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL rx_issue: req=%b we=%b addr=%0d busy=%b need 1 0 0 1",
                     bus_req, bus_we, bus_addr, busy);
        end
        irq = 1'b0; bus_ack = 1'b1; bus_rdata = 8'hA5;
        step();
        bus_ack = 1'b0;
        checks++;
        if ({bus_req, rx_valid, rx_data} !== {1'b0, 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL rx_deliver: req=%b rxv=%b rxd=%h need 0 1 a5", bus_req, rx_valid, rx_data);
        end
        step();
        checks++;
        if ({rx_valid, busy} !== 2'b01) begin
            errors++; $display("FAIL rx_release: rxv/busy=%b need 01", {rx_valid, busy});
        end
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rx_holdoff: busy=%b need 1", busy);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rx_idle: busy=%b need 0", busy);
        end
    endtask

    task automatic test_backpressure();
        irq = 1'b1; interrupt_type = 3'b010; rx_ready = 1'b0;
        step();
        bus_ack = 1'b1; bus_rdata = 8'h5A;
        step();
        bus_ack = 1'b0;
        // irq stays asserted: no new access may be issued while the byte waits
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({rx_valid, rx_data, bus_req} !== {1'b1, 8'h5A, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: rxv=%b rxd=%h req=%b need 1 5a 0",
                         i, rx_valid, rx_data, bus_req);
            end
        end
        irq = 1'b0; rx_ready = 1'b1;
        step();
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: rxv=%b need 0", rx_valid);
        end
        step(); step();
    endtask

    task automatic test_error();
        irq = 1'b1; interrupt_type = 3'b001;
        step();
        checks++;
        if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 3'd5}) begin
            errors++;
            $display("FAIL err_issue: req=%b we=%b addr=%0d need 1 0 5", bus_req, bus_we, bus_addr);
        end
        irq = 1'b0; bus_ack = 1'b1; bus_rdata = 8'h8E;
        step();
        bus_ack = 1'b0; bus_rdata = 8'h00;
        checks++;
        if ({bus_req, err_valid, err_status, rx_valid} !== {1'b0, 1'b1, 8'h8E, 1'b0}) begin
            errors++;
            $display("FAIL err_capture: req=%b ev=%b es=%h rxv=%b need 0 1 8e 0",
                     bus_req, err_valid, err_status, rx_valid);
        end
        step();
        checks++;
        if ({err_valid, err_status, busy} !== {1'b0, 8'h8E, 1'b1}) begin
            errors++;
            $display("FAIL err_pulse: ev=%b es=%h busy=%b need 0 8e 1", err_valid, err_status, busy);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL err_idle: busy=%b need 0", busy);
        end
    endtask

    task automatic test_tx();
        irq = 1'b1; interrupt_type = 3'b011; tx_valid = 1'b0; tx_data = 8'h3C;
        #1;
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++; $display("FAIL tx_no_data_ready: tx_ready=%b need 0", tx_ready);
        end
        step();
        checks++;
        if ({bus_req, busy} !== 2'b00) begin
            errors++; $display("FAIL tx_no_data_access: req/busy=%b need 00", {bus_req, busy});
        end
        tx_valid = 1'b1;
        #1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++; $display("FAIL tx_ready_pulse: tx_ready=%b need 1", tx_ready);
        end
        step();
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, tx_ready} !== {1'b1, 1'b1, 3'd0, 8'h3C, 1'b0}) begin
            errors++;
            $display("FAIL tx_issue: req=%b we=%b addr=%0d wd=%h txr=%b need 1 1 0 3c 0",
                     bus_req, bus_we, bus_addr, bus_wdata, tx_ready);
        end
        irq = 1'b0; tx_valid = 1'b0; bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        checks++;
        if ({bus_req, busy, rx_valid} !== 3'b010) begin
            errors++; $display("FAIL tx_done: req/busy/rxv=%b need 010", {bus_req, busy, rx_valid});
        end
        step(); step();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        irq = 1'b1; interrupt_type = 3'b010; rx_ready = 1'b1;
        step();
        irq = 1'b0;
        if (bus_req === 1'b1) req_cycles++;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus_req === 1'b1) req_cycles++;
            checks++;
            if (bus_timeout !== 1'b0) begin
                errors++; $display("FAIL to_early[%0d]: bus_timeout=%b need 0", i, bus_timeout);
            end
        end
        step();
        checks++;
        if ({req_cycles, bus_req, bus_timeout, rx_valid} !== {32'd16, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL to_abort: req_cycles=%0d req=%b to=%b rxv=%b need 16 0 1 0",
                     req_cycles, bus_req, bus_timeout, rx_valid);
        end
        step();
        checks++;
        if ({bus_timeout, busy} !== 2'b01) begin
            errors++; $display("FAIL to_pulse: to/busy=%b need 01", {bus_timeout, busy});
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL to_idle: busy=%b need 0", busy);
        end
    endtask

    task automatic test_ack_at_timeout();
        irq = 1'b1; interrupt_type = 3'b010; rx_ready = 1'b1;
        step();
        irq = 1'b0;
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (bus_req !== 1'b1) begin
            errors++; $display("FAIL ack_last_req: bus_req=%b need 1", bus_req);
        end
        bus_ack = 1'b1; bus_rdata = 8'h77;
        step();
        bus_ack = 1'b0;
        checks++;
        if ({bus_req, bus_timeout, rx_valid, rx_data} !== {1'b0, 1'b0, 1'b1, 8'h77}) begin
            errors++;
            $display("FAIL ack_wins: req=%b to=%b rxv=%b rxd=%h need 0 0 1 77",
                     bus_req, bus_timeout, rx_valid, rx_data);
        end
        step();
        checks++;
        if ({rx_valid, bus_timeout} !== 2'b00) begin
            errors++; $display("FAIL ack_wins_after: rxv/to=%b need 00", {rx_valid, bus_timeout});
        end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_rx();
        test_backpressure();
        test_error();
        test_tx();
        test_timeout();
        test_ack_at_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
